// File: rtl/soundgen_pkg.sv
// Shared types and constants for the sound generator's melody controller:
// sequencer states, song-entry field layout and the octave-7 pitch table.
package soundgen_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_PLAY,
    ST_GAP,
    ST_DONE
  } seq_state_e;

  localparam int unsigned ENTRY_W  = 12;
  localparam int unsigned DUR_MSB  = 11;
  localparam int unsigned DUR_LSB  = 8;
  localparam int unsigned OCT_MSB  = 7;
  localparam int unsigned OCT_LSB  = 4;
  localparam int unsigned SEMI_MSB = 3;
  localparam int unsigned SEMI_LSB = 0;

  localparam logic [3:0] END_DUR  = 4'd0;
  localparam logic [3:0] REST_MIN = 4'd12;

  // C7..B7 increments for a 50 MHz clock driving a 28-bit phase accumulator
  localparam int unsigned TABLE_W = 16;
  localparam logic [TABLE_W-1:0] INCR_TABLE [12] = '{
    16'd11237, 16'd11905, 16'd12613, 16'd13363,
    16'd14157, 16'd14999, 16'd15891, 16'd16836,
    16'd17837, 16'd18898, 16'd20022, 16'd21212
  };

  function automatic logic [TABLE_W-1:0] incr_base(input logic [3:0] semi);
    logic [TABLE_W-1:0] val;
    val = '0;
    if (semi < REST_MIN) val = INCR_TABLE[semi];
    return val;
  endfunction

endpackage

// File: rtl/tempo_tick.sv
// Tempo divider: one-cycle tick every TICK_DIV clocks, counted from the
// last synchronous restart.
module tempo_tick #(
  parameter int unsigned TICK_DIV = 12500
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (restart || (cnt_q == LAST)) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/note_sequencer.sv
// Melody controller: fetches song entries, times notes and gaps on tempo
// ticks, and drives the tone generator's gate and phase increment.
module note_sequencer
  import soundgen_pkg::*;
#(
  parameter int unsigned ADDR_W    = 6,
  parameter int unsigned TICK_DIV  = 12500,
  parameter int unsigned GAP_TICKS = 1,
  parameter int unsigned INCR_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_en,
  input  logic [11:0]       rom_data,
  output logic [INCR_W-1:0] phase_incr,
  output logic              gate,
  output logic              note_strobe,
  output logic              busy,
  output logic              done
);

  localparam int unsigned GAP_W = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;

  seq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [INCR_W-1:0] incr_q, incr_d;
  logic              gate_q, gate_d;
  logic              strobe_q, strobe_d;
  logic [3:0]        dur_q, dur_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              tick;
  logic              restart;

  logic [3:0]        ent_dur, ent_oct, ent_semi;
  logic              is_rest;
  logic [INCR_W-1:0] base_incr, pitch_incr;

  assign ent_dur  = rom_data[DUR_MSB:DUR_LSB];
  assign ent_oct  = rom_data[OCT_MSB:OCT_LSB];
  assign ent_semi = rom_data[SEMI_MSB:SEMI_LSB];
  assign is_rest  = (ent_semi >= REST_MIN);

  assign base_incr  = INCR_W'(incr_base(ent_semi));
  assign pitch_incr = base_incr >> (4'd7 - ent_oct);

  assign restart = stop | (state_q == ST_LOAD);

  tempo_tick #(
    .TICK_DIV(TICK_DIV)
  ) u_tempo_tick (
    .clk    (clk),
    .rst    (reset),
    .restart(restart),
    .tick   (tick)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    incr_d   = incr_q;
    gate_d   = gate_q;
    strobe_d = 1'b0;
    dur_d    = dur_q;
    gap_d    = gap_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_FETCH;
          addr_d  = '0;
        end
      end
      ST_FETCH: state_d = ST_LOAD;
      ST_LOAD: begin
        if (ent_dur == END_DUR) begin
          gate_d = 1'b0;
          incr_d = '0;
          if (loop_en) begin
            addr_d  = '0;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          dur_d   = ent_dur;
          state_d = ST_PLAY;
          if (is_rest) begin
            gate_d = 1'b0;
            incr_d = '0;
          end else begin
            gate_d   = 1'b1;
            incr_d   = pitch_incr;
            strobe_d = 1'b1;
          end
        end
      end
      ST_PLAY: begin
        if (tick) begin
          if (dur_q == 4'd1) begin
            dur_d  = '0;
            gate_d = 1'b0;
            incr_d = '0;
            if (GAP_TICKS > 0) begin
              gap_d   = GAP_W'(GAP_TICKS);
              state_d = ST_GAP;
            end else begin
              addr_d  = addr_q + 1'b1;
              state_d = ST_FETCH;
            end
          end else begin
            dur_d = dur_q - 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (tick) begin
          if (gap_q == GAP_W'(1)) begin
            gap_d   = '0;
            addr_d  = addr_q + 1'b1;
            state_d = ST_FETCH;
          end else begin
            gap_d = gap_q - 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (start) begin
          state_d = ST_FETCH;
          addr_d  = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort overrides whatever the state decode chose this cycle
    if (stop) begin
      state_d  = ST_IDLE;
      addr_d   = '0;
      incr_d   = '0;
      gate_d   = 1'b0;
      strobe_d = 1'b0;
      dur_d    = '0;
      gap_d    = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      incr_q   <= '0;
      gate_q   <= 1'b0;
      strobe_q <= 1'b0;
      dur_q    <= '0;
      gap_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      incr_q   <= incr_d;
      gate_q   <= gate_d;
      strobe_q <= strobe_d;
      dur_q    <= dur_d;
      gap_q    <= gap_d;
    end
  end

  assign rom_addr    = addr_q;
  assign rom_en      = (state_q == ST_FETCH);
  assign phase_incr  = incr_q;
  assign gate        = gate_q;
  assign note_strobe = strobe_q;
  assign busy        = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done        = (state_q == ST_DONE);

endmodule

// File: tb/tb_note_sequencer.sv
// Self-checking bench for note_sequencer: a song-level timeline model
// predicts every output cycle, plus hand-computed literal checks.
module tb_note_sequencer;

  localparam int ADDR_W    = 2;
  localparam int TICK_DIV  = 4;
  localparam int GAP_TICKS = 1;
  localparam int INCR_W    = 16;
  localparam int ROM_N     = 4;

  localparam int OCT7 [12] = '{11237, 11905, 12613, 13363, 14157, 14999,
                               15891, 16836, 17837, 18898, 20022, 21212};

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic              loop_en = 1'b0;
  logic [ADDR_W-1:0] rom_addr;
  logic              rom_en;
  logic [11:0]       rom_data = '0;
  logic [INCR_W-1:0] phase_incr;
  logic              gate, note_strobe, busy, done;

  logic [11:0] rom [ROM_N];

  note_sequencer #(
    .ADDR_W   (ADDR_W),
    .TICK_DIV (TICK_DIV),
    .GAP_TICKS(GAP_TICKS),
    .INCR_W   (INCR_W)
  ) u_dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
    .loop_en    (loop_en),
    .rom_addr   (rom_addr),
    .rom_en     (rom_en),
    .rom_data   (rom_data),
    .phase_incr (phase_incr),
    .gate       (gate),
    .note_strobe(note_strobe),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rom_en) rom_data <= rom[rom_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef logic [22:0] obs_t;
  obs_t exp_q[$];
  int   tail_done = 0;
  int   tail_addr = 0;
  int   gen_budget = 8;
  bit   cmp_en = 1'b0;

  int n_checks = 0;
  int n_fail = 0;

  int strobe_cnt, gate_cnt, first_gate, done_seen, wrap_seen, prev_addr;
  int phase_seen;
  int start_edge;

  function automatic obs_t pack(input int a, input int en, input int ph,
                                input int g, input int s, input int b, input int d);
    obs_t o;
    o = {2'(a), 1'(en), 16'(ph), 1'(g), 1'(s), 1'(b), 1'(d)};
    return o;
  endfunction

  function automatic int pitch(input int oct, input int semi);
    return (OCT7[semi] * (1 << oct)) / 128;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Expand the song in ROM into the cycle-by-cycle output timeline
  task automatic gen_song(input int budget);
    int a;
    logic [11:0] e;
    int dur, oct, semi, ph;
    bit snd;
    a = 0;
    tail_done = 0;
    tail_addr = 0;
    for (int n = 0; n < budget; n++) begin
      e = rom[a];
      dur = int'(e[11:8]);
      oct = int'(e[7:4]);
      semi = int'(e[3:0]);
      exp_q.push_back(pack(a, 1, 0, 0, 0, 1, 0));
      exp_q.push_back(pack(a, 0, 0, 0, 0, 1, 0));
      if (dur == 0) begin
        if (loop_en) begin
          a = 0;
          continue;
        end
        tail_done = 1;
        tail_addr = a;
        return;
      end
      snd = (semi < 12);
      ph = snd ? pitch(oct, semi) : 0;
      for (int c = 0; c < dur * TICK_DIV; c++)
        exp_q.push_back(pack(a, 0, ph, int'(snd), int'(snd && c == 0), 1, 0));
      for (int c = 0; c < GAP_TICKS * TICK_DIV; c++)
        exp_q.push_back(pack(a, 0, 0, 0, 0, 1, 0));
      a = (a + 1) % ROM_N;
    end
  endtask

  always @(negedge clk) begin
    obs_t act, exp_v;
    bit steady;
    if (reset) begin
      exp_q.delete();
      tail_done = 0;
      tail_addr = 0;
    end
    act = {rom_addr, rom_en, phase_incr, gate, note_strobe, busy, done};
    steady = (exp_q.size() == 0);
    exp_v = steady ? pack(tail_addr, 0, 0, 0, 0, 0, tail_done) : exp_q.pop_front();
    if (cmp_en) check("cycle {addr,en,incr,gate,strobe,busy,done}", 64'(act), 64'(exp_v));

    if (gate) begin
      gate_cnt++;
      if (first_gate < 0) first_gate = cyc;
    end
    if (note_strobe) begin
      strobe_cnt++;
      phase_seen = int'(phase_incr);
    end
    if (done) done_seen++;
    if (busy && prev_addr == 3 && int'(rom_addr) == 0) wrap_seen++;
    prev_addr = int'(rom_addr);

    if (!reset) begin
      if (stop) begin
        exp_q.delete();
        tail_done = 0;
        tail_addr = 0;
      end else if (start && steady) begin
        gen_song(gen_budget);
      end
    end
  end

  task automatic clear_stats();
    strobe_cnt = 0;
    gate_cnt = 0;
    first_gate = -1;
    done_seen = 0;
    wrap_seen = 0;
    prev_addr = 0;
    phase_seen = -1;
  endtask

  task automatic start_song();
    @(posedge clk); #1;
    start = 1'b1;
    start_edge = cyc + 1;
    @(posedge clk); #1;
    start = 1'b0;
    clear_stats();
  endtask

  task automatic stop_pulse();
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    for (int i = 0; i < limit; i++) begin
      if (done) break;
      @(posedge clk); #1;
    end
    check("done_reached", 64'(done), 64'(1));
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_rom_addr"}, 64'(rom_addr), 64'(0));
    check({tag, "_rom_en"}, 64'(rom_en), 64'(0));
    check({tag, "_phase_incr"}, 64'(phase_incr), 64'(0));
    check({tag, "_gate"}, 64'(gate), 64'(0));
    check({tag, "_note_strobe"}, 64'(note_strobe), 64'(0));
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_done"}, 64'(done), 64'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    clear_stats();
    for (int i = 0; i < ROM_N; i++) rom[i] = '0;
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    reset = 1'b0;
    cmp_en = 1'b1;

    // Single note A4 for 3 ticks, then end marker
    rom[0] = 12'h349; rom[1] = 12'h000; rom[2] = 12'h000; rom[3] = 12'h000;
    loop_en = 1'b0;
    gen_budget = 8;
    start_song();
    wait_done(100);
    check("single_gate_cycles", 64'(gate_cnt), 64'(12));
    check("single_strobes", 64'(strobe_cnt), 64'(1));
    check("single_phase", 64'(phase_seen), 64'(2362));
    check("single_gate_latency", 64'(first_gate - start_edge), 64'(2));
    check("single_busy_at_done", 64'(busy), 64'(0));

    // Rest for 2 ticks, then C5 for 1 tick, restarted from DONE
    rom[0] = 12'h20C; rom[1] = 12'h150; rom[2] = 12'h000;
    start_song();
    wait_done(100);
    check("rest_gate_cycles", 64'(gate_cnt), 64'(4));
    check("rest_strobes", 64'(strobe_cnt), 64'(1));
    check("rest_phase", 64'(phase_seen), 64'(2809));
    check("rest_gate_latency", 64'(first_gate - start_edge), 64'(16));

    // Looping song: C4 then end marker with loop_en
    rom[0] = 12'h140; rom[1] = 12'h000;
    loop_en = 1'b1;
    gen_budget = 10;
    start_song();
    repeat (35) @(posedge clk);
    #1;
    stop_pulse();
    check("loop_strobes", 64'(strobe_cnt), 64'(3));
    check("loop_done_seen", 64'(done_seen), 64'(0));
    check("loop_phase", 64'(phase_seen), 64'(1404));
    check("loop_busy_after_stop", 64'(busy), 64'(0));
    loop_en = 1'b0;

    // Stop in the sixth cycle of a note
    rom[0] = 12'h349; rom[1] = 12'h000;
    gen_budget = 8;
    start_song();
    repeat (7) @(posedge clk);
    #1;
    stop_pulse();
    check("stop_gate_cycles", 64'(gate_cnt), 64'(6));
    check_idle_outputs("stop");

    // start and stop together while idle
    start = 1'b1;
    stop = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    stop = 1'b0;
    check("startstop_busy", 64'(busy), 64'(0));
    check("startstop_rom_en", 64'(rom_en), 64'(0));
    repeat (3) @(posedge clk);
    #1;

    // Address wrap 3 -> 0 with no end marker
    rom[0] = 12'h140; rom[1] = 12'h152; rom[2] = 12'h164; rom[3] = 12'h179;
    gen_budget = 8;
    start_song();
    repeat (45) @(posedge clk);
    #1;
    stop_pulse();
    check("wrap_seen", 64'(wrap_seen), 64'(1));
    check("wrap_strobes", 64'(strobe_cnt), 64'(5));
    check("wrap_last_phase", 64'(phase_seen), 64'(1404));

    // Async reset between clock edges during a note
    rom[0] = 12'h349; rom[1] = 12'h000; rom[2] = 12'h000; rom[3] = 12'h000;
    start_song();
    repeat (5) @(posedge clk);
    #3;
    check("pre_reset_gate", 64'(gate), 64'(1));
    reset = 1'b1;
    #1;
    check_idle_outputs("async_reset");
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/note_sequencer.md
Name: note_sequencer

Overview:
Melody controller that sequences the PWM tone datapath of the sound generator. It fetches note entries from a synchronous song ROM and converts pitch codes to phase increments for the tone generator. It times each note with a tempo-tick divider, inserts articulation gaps between notes, and handles start, stop, loop and end-of-song. It sits between the top level and the tone/PWM generator, and owns the generator's gate and frequency inputs.

Parameters:
ADDR_W, 6, song ROM address width (64 entries)
TICK_DIV, 12500, clk cycles per tempo tick; minimum 2
GAP_TICKS, 1, silent ticks inserted after every note; 0 means legato, no gap
INCR_W, 16, phase-increment width

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  level-sampled; begins playback from address 0 when idle
stop  in  1  aborts playback; wins over start
loop_en  in  1  at end marker: 1 restarts at address 0, 0 finishes
rom_addr  out  ADDR_W  song ROM address
rom_en  out  1  ROM read strobe; data valid the cycle after
rom_data  in  12  entry: [11:8] duration in ticks (0 = end marker), [7:4] octave 0-7 (bit 7 reserved, must be 0), [3:0] semitone 0-11, 12-15 = rest
phase_incr  out  INCR_W  tone generator increment; 0 when silent
gate  out  1  tone generator enable
note_strobe  out  1  one-cycle pulse when a sounding note is loaded
busy  out  1  high in every state except IDLE and DONE
done  out  1  high in DONE

Behaviour:
- Reset (async) values: state=IDLE; rom_addr=0; rom_en=0; phase_incr=0; gate=0; note_strobe=0; busy=0; done=0. Tick and duration counters clear.
- States: IDLE, FETCH, LOAD, PLAY, GAP, DONE.
- IDLE: start=1 and stop=0 -> FETCH with rom_addr=0.
- FETCH: rom_en=1 for one cycle -> LOAD.
- LOAD: rom_data sampled.
  - dur=0 and loop_en=1: rom_addr=0 -> FETCH.
  - dur=0 and loop_en=0: -> DONE, gate=0, phase_incr=0.
  - otherwise: dur_cnt=dur; tick divider restarts; -> PLAY.
  - Sounding note: gate=1, phase_incr=lookup, note_strobe=1 in this cycle.
  - Rest: gate=0, phase_incr=0, no strobe.
- Gate timing: gate rises exactly 2 cycles after the clock edge that samples start in IDLE (IDLE->FETCH->LOAD; gate is registered and valid from PLAY entry).
- PLAY: tick asserts every TICK_DIV cycles after the divider restart; each tick decrements dur_cnt. When dur_cnt reaches 0 on a tick: gate=0, phase_incr=0.
  - GAP_TICKS>0: -> GAP.
  - GAP_TICKS=0: rom_addr+1 -> FETCH.
- GAP: lasts GAP_TICKS ticks, then rom_addr+1 -> FETCH.
- rom_addr increments modulo 2^ADDR_W; wrap to 0 is normal continuation, not an end.
- DONE: done=1; start=1 -> FETCH at address 0; stop=1 -> IDLE.
- stop=1 in any state -> IDLE next cycle with all outputs at reset values. stop has priority over every other transition, including start and tick in the same cycle.
- Pitch lookup: base = INCR_TABLE[semitone], the octave-7 increment. phase_incr = base >> (7-octave), logical shift, result INCR_W bits.
- loop_en is sampled only in LOAD. start is ignored while busy.

Decomposition:
- Package soundgen_pkg holds:
  - state enum
  - entry field bit positions
  - END_DUR=0, REST_MIN=12
  - INCR_TABLE: 12 x INCR_W constants, C7..B7, derived for the system clock and generator accumulator width
- One sub-module, tempo_tick: divider with sync restart input; single-cycle tick output every TICK_DIV cycles.
- Pitch lookup stays inline as combinational logic.

Test Plan:
- Use TICK_DIV=4 and GAP_TICKS=1 for all scenarios unless stated.
- Single note then end: ROM[0]=0x3_4_9 (dur 3, octave 4, A), ROM[1]=0x000, loop_en=0, pulse start. Required: gate high 12 cycles; phase_incr=INCR_TABLE[9]>>3; then one gap tick (4 cycles); then done=1, busy=0. note_strobe pulses once.
- Rest entry: ROM[0]=0x2_0_C, ROM[1]=0x1_5_0, ROM[2]=0x000. Required: gate=0 and phase_incr=0 for 8 cycles, no note_strobe, then the C5 note sounds for 4 cycles.
- Loop: ROM[0]=0x1_4_0, ROM[1]=0x000, loop_en=1. Required: rom_addr sequence 0,1,0,1,...; done never asserts; note_strobe once per pass.
- Stop mid-note: stop=1 on cycle 6 of PLAY. Required: next cycle IDLE; gate=0, phase_incr=0, busy=0. start and stop asserted together in IDLE: stays IDLE.
- Address wrap: ADDR_W=2, ROM[0..3] all notes with dur 1, no end marker. Required: rom_addr 3 -> 0 with continuous playback.
- Async reset asserted mid-PLAY, between clock edges. Required: all outputs at reset values immediately, before the next clock edge.
